// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode/funct constants
// and the instruction-queue entry payload.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    // Field positions within an instruction word
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned FN_MSB = 5;
    localparam int unsigned FN_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef struct packed {
        logic              is_ctrl;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/ctrl_predecode.sv
// Flags control-transfer instructions (beq, bne, j, jal, jr) from the raw word.
module ctrl_predecode
    import cpu_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output logic              is_ctrl
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [19:0] w_unused_mid;

    assign w_op         = inst[OP_MSB:OP_LSB];
    assign w_funct      = inst[FN_MSB:FN_LSB];
    assign w_unused_mid = inst[OP_LSB-1:FN_MSB+1];

    always_comb begin
        is_ctrl = 1'b0;
        case (w_op)
            OP_J, OP_JAL, OP_BEQ, OP_BNE: is_ctrl = 1'b1;
            OP_RTYPE:                     is_ctrl = (w_funct == FUNCT_JR);
            default:                      is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO (first-word-fall-through) with a stored
// control-transfer flag per entry and a single-cycle flush.
module inst_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [INST_W-1:0]       in_inst,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [PC_W-1:0]         out_pc,
    output logic [INST_W-1:0]       out_inst,
    output logic                    out_is_ctrl,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic      w_is_ctrl;
    logic      w_push;
    logic      w_pop;
    iq_entry_t w_head;

    ctrl_predecode u_predecode (
        .inst    (in_inst),
        .is_ctrl (w_is_ctrl)
    );

    // Readiness ignores out_ready: a full queue never accepts, even on a pop
    assign in_ready  = rst && (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && rst && !flush;

    assign w_head      = r_mem[r_head];
    assign out_pc      = w_head.pc;
    assign out_inst    = w_head.inst;
    assign out_is_ctrl = w_head.is_ctrl;
    assign level       = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {w_is_ctrl, in_pc, in_inst};
        end
    end

    // Reset and flush share the same clearing effect
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_is_ctrl;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_is_ctrl (out_is_ctrl),
        .out_ready   (out_ready),
        .flush       (flush),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ctrl;
    } ent_t;

    ent_t mq[$];
    bit   m_init   = 1'b0;
    bit   m_pushed = 1'b0;

    function automatic logic ref_ctrl(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return (op inside {6'h02, 6'h03, 6'h04, 6'h05}) || (op == 6'h00 && i[5:0] == 6'h08);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue as an ordered list of entries
    always @(posedge clk) begin
        bit   ready;
        bit   push;
        bit   pop;
        ent_t e;
        ready = rst && (mq.size() < DEPTH);
        push  = in_valid && ready;
        pop   = out_ready && (mq.size() != 0);
        if (!rst || flush) begin
            mq.delete();
            m_pushed = 1'b0;
            if (!rst) m_init = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc   = in_pc;
                e.inst = in_inst;
                e.ctrl = ref_ctrl(in_inst);
                mq.push_back(e);
            end
            m_pushed = push;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(rst && (mq.size() < DEPTH)));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            if (mq.size() != 0) begin
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_inst", out_inst, mq[0].inst);
                chk("out_is_ctrl", 32'(out_is_ctrl), 32'(mq[0].ctrl));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] mid;
        op  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
        fn  = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
        mid = 20'($urandom);
        return {op, mid, fn};
    endfunction

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pc    = base + 32'(4 * i);
            in_inst  = 32'h2008_0000 + 32'(i);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    logic [31:0] ctrl_insts [4];
    logic        ctrl_exp   [4];

    initial begin
        // Reset for two cycles
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single push, visible one cycle later
        in_valid = 1'b1;
        in_pc    = 32'h0;
        in_inst  = 32'h2008_0005;
        cyc();
        in_valid = 1'b0;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_pc", out_pc, 32'h0);
        chk("one_inst", out_inst, 32'h2008_0005);
        chk("one_ctrl", 32'(out_is_ctrl), 32'd0);
        chk("one_level", 32'(level), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush1_level", 32'(level), 32'd0);

        // Fill, hold a fifth push, then drain
        push_n(4, 32'h0);
        in_valid = 1'b1;
        in_pc    = 32'h10;
        in_inst  = 32'h2008_0004;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(level), 32'd4);
        cyc();
        chk("held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        cyc();
        chk("pop0_level", 32'(level), 32'd3);
        chk("pop0_in_ready", 32'(in_ready), 32'd1);
        chk("pop0_pc", out_pc, 32'h04);
        cyc();
        in_valid = 1'b0;
        chk("pop1_level", 32'(level), 32'd3);
        chk("pop1_pc", out_pc, 32'h08);
        cyc();
        chk("pop2_pc", out_pc, 32'h0C);
        cyc();
        chk("pop3_pc", out_pc, 32'h10);
        cyc();
        chk("drain_level", 32'(level), 32'd0);

        // Continuous stream through a one-deep occupancy, wrapping pointers
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h100 + 32'(4 * i);
            in_inst  = 32'h0022_1820;
            cyc();
            chk("stream_level", 32'(level), 32'd1);
            chk("stream_pc", out_pc, 32'h100 + 32'(4 * i));
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        chk("stream_end_level", 32'(level), 32'd0);

        // Control-transfer predecode
        ctrl_insts = '{32'h1022_0003, 32'h0800_0010, 32'h03E0_0008, 32'h0022_1820};
        ctrl_exp   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(4 * i);
            in_inst  = ctrl_insts[i];
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ctrl_flag", 32'(out_is_ctrl), 32'(ctrl_exp[i]));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end

        // Flush with concurrent push and pop
        push_n(3, 32'h300);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("flush_discard", 32'(level), 32'd0);

        // Reset together with flush
        push_n(3, 32'h400);
        rst       = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("rstf_level", 32'(level), 32'd0);
        chk("rstf_out_valid", 32'(out_valid), 32'd0);
        chk("rstf_in_ready_low", 32'(in_ready), 32'd0);
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rstf_in_ready", 32'(in_ready), 32'd1);

        // Random traffic; offered data is held until accepted
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !m_pushed)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_pc    = $urandom;
                in_inst  = rand_inst();
            end
            case ((c / 500) % 3)
                0:       out_ready = ($urandom_range(0, 3) == 0);
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            flush = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
